// File: rtl/hood_mode_if.sv
// Request/status bundle between the hood mode controller and its user.
// The user side (master) drives the request levels and the cumulative-clear.
// The controller side (slave) returns the mode and the two timers.
interface hood_mode_if;
    logic       req_standby;
    logic       req_l1;
    logic       req_l2;
    logic       req_hurr;
    logic       clr_cum;
    logic [2:0] mode_state;
    logic [5:0] cd_min;
    logic [5:0] cd_sec;
    logic [5:0] cum_min;
    logic [5:0] cum_sec;
    logic       hurr_used;

    modport master (
        output req_standby, req_l1, req_l2, req_hurr, clr_cum,
        input  mode_state, cd_min, cd_sec, cum_min, cum_sec, hurr_used
    );

    modport slave (
        input  req_standby, req_l1, req_l2, req_hurr, clr_cum,
        output mode_state, cd_min, cd_sec, cum_min, cum_sec, hurr_used
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Range-hood fan mode controller on a 1 Hz tick.
// Modes: standby, level 1, level 2, a one-shot timed hurricane boost, and a
// timed cooldown entered by cancelling hurricane. Requests act on rising
// edges with priority standby > hurricane > level 2 > level 1. A cumulative
// run-time clock counts every second spent outside standby.
module hood_mode_ctrl #(
    parameter int CD_SEC = 60
) (
    input logic         clk_1hz,
    input logic         rst,
    hood_mode_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_STANDBY = 3'b000,
        ST_L1      = 3'b001,
        ST_L2      = 3'b010,
        ST_HURR    = 3'b011,
        ST_COOL    = 3'b100
    } mode_e;

    localparam logic [5:0] CD_LOAD_MIN = 6'(CD_SEC / 60);
    localparam logic [5:0] CD_LOAD_SEC = 6'(CD_SEC % 60);

    // Request bit order throughout: {standby, hurr, l2, l1}.
    localparam int R_STBY = 3;
    localparam int R_HURR = 2;
    localparam int R_L2   = 1;
    localparam int R_L1   = 0;

    mode_e      mode_q,      mode_d;
    logic [5:0] cd_min_q,    cd_min_d;
    logic [5:0] cd_sec_q,    cd_sec_d;
    logic [5:0] cum_min_q,   cum_min_d;
    logic [5:0] cum_sec_q,   cum_sec_d;
    logic       hurr_used_q, hurr_used_d;
    logic [3:0] req_prev_q;

    logic [3:0] req_now;
    logic [3:0] req_rise;
    logic       cd_last;
    logic [5:0] cd_dec_min;
    logic [5:0] cd_dec_sec;

    assign req_now  = {bus.req_standby, bus.req_hurr, bus.req_l2, bus.req_l1};
    assign req_rise = req_now & ~req_prev_q;

    // Countdown helpers: "one second left" and the mm:ss borrow decrement.
    assign cd_last    = (cd_min_q == 6'd0) && (cd_sec_q == 6'd1);
    assign cd_dec_min = (cd_sec_q == 6'd0) ? cd_min_q - 6'd1 : cd_min_q;
    assign cd_dec_sec = (cd_sec_q == 6'd0) ? 6'd59 : cd_sec_q - 6'd1;

    // Mode transitions and countdown next-state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        mode_d      = mode_q;
        cd_min_d    = 6'd0;
        cd_sec_d    = 6'd0;
        hurr_used_d = hurr_used_q;

        unique case (mode_q)
            ST_STANDBY, ST_L1, ST_L2: begin
                if (req_rise[R_STBY]) begin
                    mode_d = ST_STANDBY;
                end else if (req_rise[R_HURR] && !hurr_used_q) begin
                    mode_d      = ST_HURR;
                    hurr_used_d = 1'b1;
                    cd_min_d    = CD_LOAD_MIN;
                    cd_sec_d    = CD_LOAD_SEC;
                end else if (req_rise[R_L2]) begin
                    mode_d = ST_L2;
                end else if (req_rise[R_L1]) begin
                    mode_d = ST_L1;
                end
            end
            ST_HURR: begin
                if (req_rise[R_STBY]) begin
                    mode_d   = ST_COOL;
                    cd_min_d = CD_LOAD_MIN;
                    cd_sec_d = CD_LOAD_SEC;
                end else if (cd_last) begin
                    mode_d = ST_L2;
                end else begin
                    cd_min_d = cd_dec_min;
                    cd_sec_d = cd_dec_sec;
                end
            end
            ST_COOL: begin
                if (cd_last) begin
                    mode_d = ST_STANDBY;
                end else begin
                    cd_min_d = cd_dec_min;
                    cd_sec_d = cd_dec_sec;
                end
            end
            default: begin
                mode_d = ST_STANDBY;
            end
        endcase
    end

    // Cumulative run time: clear wins, otherwise count seconds outside standby.
    always_comb begin
        cum_min_d = cum_min_q;
        cum_sec_d = cum_sec_q;
        if (bus.clr_cum) begin
            cum_min_d = 6'd0;
            cum_sec_d = 6'd0;
        end else if (mode_q != ST_STANDBY) begin
            if (cum_sec_q == 6'd59) begin
                cum_sec_d = 6'd0;
                cum_min_d = (cum_min_q == 6'd59) ? 6'd0 : cum_min_q + 6'd1;
            end else begin
                cum_sec_d = cum_sec_q + 6'd1;
            end
        end
    end

    // State registers; reset clears everything including the hurricane one-shot.
    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            mode_q      <= ST_STANDBY;
            cd_min_q    <= 6'd0;
            cd_sec_q    <= 6'd0;
            cum_min_q   <= 6'd0;
            cum_sec_q   <= 6'd0;
            hurr_used_q <= 1'b0;
            req_prev_q  <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, matching hardware flops.
            mode_q      <= mode_d;
            cd_min_q    <= cd_min_d;
            cd_sec_q    <= cd_sec_d;
            cum_min_q   <= cum_min_d;
            cum_sec_q   <= cum_sec_d;
            hurr_used_q <= hurr_used_d;
            req_prev_q  <= req_now;
        end
    end

    assign bus.mode_state = mode_q;
    assign bus.cd_min     = cd_min_q;
    assign bus.cd_sec     = cd_sec_q;
    assign bus.cum_min    = cum_min_q;
    assign bus.cum_sec    = cum_sec_q;
    assign bus.hurr_used  = hurr_used_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Self-checking bench for hood_mode_ctrl: directed scenarios plus random
// request traffic, compared against a seconds-based reference model.
module tb_hood_mode_ctrl;

    localparam int CD = 60;

    logic clk_1hz = 1'b0;
    logic rst     = 1'b0;

    always #5 clk_1hz = ~clk_1hz;

    hood_mode_if bus ();

    hood_mode_ctrl #(.CD_SEC(CD)) dut (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode number, countdown and cumulative time as plain seconds.
    int       m_mode;
    int       m_cd;
    int       m_cum;
    bit       m_used;
    bit [3:0] m_prev;   // {standby, hurr, l2, l1}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cd   = 0;
        m_cum  = 0;
        m_used = 1'b0;
        m_prev = 4'b0000;
    endtask

    // One tick of the rules: pick the highest-priority meaningful rising request.
    task automatic model_step(input bit [3:0] now, input bit clr);
        bit [3:0] rise;
        int       pre_mode;
        rise     = now & ~m_prev;
        pre_mode = m_mode;
        case (pre_mode)
            0, 1, 2: begin
                if (rise[3])                  m_mode = 0;
                else if (rise[2] && !m_used) begin
                    m_mode = 3;
                    m_used = 1'b1;
                    m_cd   = CD;
                end
                else if (rise[1])             m_mode = 2;
                else if (rise[0])             m_mode = 1;
            end
            3: begin
                if (rise[3]) begin
                    m_mode = 4;
                    m_cd   = CD;
                end else begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) m_mode = 2;
                end
            end
            default: begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_mode = 0;
            end
        endcase
        if (clr)                m_cum = 0;
        else if (pre_mode != 0) m_cum = (m_cum + 1) % 3600;
        m_prev = now;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".mode"},    32'(bus.mode_state), 32'(m_mode));
        check({tag, ".cd_min"},  32'(bus.cd_min),     32'(m_cd / 60));
        check({tag, ".cd_sec"},  32'(bus.cd_sec),     32'(m_cd % 60));
        check({tag, ".cum_min"}, 32'(bus.cum_min),    32'(m_cum / 60));
        check({tag, ".cum_sec"}, 32'(bus.cum_sec),    32'(m_cum % 60));
        check({tag, ".used"},    32'(bus.hurr_used),  32'(m_used));
    endtask

    task automatic set_req(input bit [3:0] v);
        bus.req_standby = v[3];
        bus.req_hurr    = v[2];
        bus.req_l2      = v[1];
        bus.req_l1      = v[0];
    endtask

    // Apply one clock edge with the current inputs, step the model, then compare.
    task automatic tick(input string tag);
        bit [3:0] now;
        bit       clr;
        now = {bus.req_standby, bus.req_hurr, bus.req_l2, bus.req_l1};
        clr = bus.clr_cum;
        @(posedge clk_1hz);
        model_step(now, clr);
        #1;
        compare_all(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Rising-edge request held for exactly one clock edge.
    task automatic pulse(input string tag, input bit [3:0] v);
        set_req(v);
        tick(tag);
        set_req(4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_req(4'b0000);
        bus.clr_cum = 1'b0;
        @(negedge clk_1hz);
        model_reset();
        compare_all("reset");
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_req(4'b0000);
        bus.clr_cum = 1'b0;
        model_reset();

        // Reset release, level 1 for 65 seconds.
        do_reset();
        pulse("r29_pulse", 4'b0001);
        ticks("r29_run", 65);
        check("r29_mode",    32'(bus.mode_state), 32'd1);
        check("r29_cum_min", 32'(bus.cum_min),    32'd1);
        check("r29_cum_sec", 32'(bus.cum_sec),    32'd5);

        // Hurricane runs its full countdown then drops to L2; second request ignored.
        do_reset();
        pulse("r30_entry", 4'b0100);
        check("r30_mode",   32'(bus.mode_state), 32'd3);
        check("r30_cd_min", 32'(bus.cd_min),     32'd1);
        check("r30_cd_sec", 32'(bus.cd_sec),     32'd0);
        tick("r30_first");
        check("r30_cd59",   32'(bus.cd_sec),     32'd59);
        ticks("r30_run", CD - 2);
        check("r30_still_hurr", 32'(bus.mode_state), 32'd3);
        tick("r30_last");
        check("r30_end_mode", 32'(bus.mode_state), 32'd2);
        check("r30_end_cd",   32'({bus.cd_min, bus.cd_sec}), 32'd0);
        pulse("r30_again", 4'b0100);
        check("r30_ignored", 32'(bus.mode_state), 32'd2);
        check("r30_used",    32'(bus.hurr_used),  32'd1);

        // Cancel hurricane at 00:30 into cooldown; requests ignored there.
        do_reset();
        pulse("r31_entry", 4'b0100);
        ticks("r31_run", 30);
        check("r31_cd30", 32'(bus.cd_sec), 32'd30);
        pulse("r31_cancel", 4'b1000);
        check("r31_cool",   32'(bus.mode_state), 32'd4);
        check("r31_cd_min", 32'(bus.cd_min),     32'd1);
        check("r31_cd_sec", 32'(bus.cd_sec),     32'd0);
        for (int i = 0; i < CD - 1; i++) begin
            set_req(4'($urandom_range(0, 15)));
            tick("r31_cool_run");
        end
        check("r31_held", 32'(bus.mode_state), 32'd4);
        set_req(4'b0000);
        tick("r31_done");
        check("r31_standby", 32'(bus.mode_state), 32'd0);

        // Simultaneous standby and L2 edges while in L1.
        do_reset();
        pulse("r32_l1", 4'b0001);
        pulse("r32_both", 4'b1010);
        check("r32_mode", 32'(bus.mode_state), 32'd0);

        // Cumulative wrap at 59:59 and clear with priority.
        do_reset();
        pulse("r33_l2", 4'b0010);
        bus.clr_cum = 1'b1;
        tick("r33_clr0");
        bus.clr_cum = 1'b0;
        ticks("r33_fill", 3598);
        check("r33_pre_min", 32'(bus.cum_min), 32'd59);
        check("r33_pre_sec", 32'(bus.cum_sec), 32'd58);
        ticks("r33_wrap", 2);
        check("r33_wrap0", 32'({bus.cum_min, bus.cum_sec}), 32'd0);
        ticks("r33_more", 7);
        bus.clr_cum = 1'b1;
        tick("r33_clr");
        bus.clr_cum = 1'b0;
        check("r33_clr_cum",  32'({bus.cum_min, bus.cum_sec}), 32'd0);
        check("r33_clr_mode", 32'(bus.mode_state), 32'd2);

        // Asynchronous reset mid-hurricane, then hurricane is available again.
        do_reset();
        pulse("r34_entry", 4'b0100);
        ticks("r34_run", 10);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("r34_mode", 32'(bus.mode_state), 32'd0);
        check("r34_cd",   32'({bus.cd_min, bus.cd_sec}), 32'd0);
        check("r34_cum",  32'({bus.cum_min, bus.cum_sec}), 32'd0);
        check("r34_used", 32'(bus.hurr_used), 32'd0);
        @(posedge clk_1hz);
        #1;
        compare_all("r34_held");
        rst = 1'b1;
        pulse("r34_rearm", 4'b0100);
        check("r34_rearm_mode", 32'(bus.mode_state), 32'd3);

        // Random request traffic with occasional clears and mid-cycle resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_req(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            bus.clr_cum = ($urandom_range(0, 31) == 0);
            tick("rand");
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b0;
                #1;
                model_reset();
                compare_all("rand_rst");
                #1 rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 The block SHALL have parameter CD_SEC, default 60, meaning hurricane and cooldown countdown length in seconds (range 1..3599).
REQ-002 The block SHALL have port clk_1hz  input  1  1 Hz system tick; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_standby  input  1  standby request level (rising edge acts).
REQ-005 The block SHALL have port req_l1  input  1  level-1 request level (rising edge acts).
REQ-006 The block SHALL have port req_l2  input  1  level-2 request level (rising edge acts).
REQ-007 The block SHALL have port req_hurr  input  1  hurricane request level (rising edge acts).
REQ-008 The block SHALL have port clr_cum  input  1  synchronous clear of the cumulative timer, level-sensitive.
REQ-009 The block SHALL have port mode_state  output  3  000 standby, 001 L1, 010 L2, 011 hurricane, 100 cooldown.
REQ-010 The block SHALL have port cd_min, cd_sec  output  6 each  countdown minutes/seconds.
REQ-011 The block SHALL have port cum_min, cum_sec  output  6 each  cumulative run time minutes/seconds.
REQ-012 The block SHALL have port hurr_used  output  1  hurricane one-shot consumed.

Function
REQ-013 The block SHALL detect request edges by registering each req_* and acting when current=1 and previous=0; a request high at reset release SHALL act on the first edge.
REQ-014 The block SHALL drive all outputs from registers, with a new state visible on mode_state at the same edge that accepts the request (1-edge latency).
REQ-015 The block SHALL, for simultaneous edges, apply priority standby > hurr > l2 > l1, acting on exactly one request per edge.
REQ-016 The block SHALL, in STANDBY, move to L1/L2 on req_l1/req_l2 and to HURR on req_hurr only when hurr_used=0; otherwise it SHALL ignore req_hurr.
REQ-017 The block SHALL, in L1 or L2, switch directly between L1 and L2, go to STANDBY on req_standby, and go to HURR on req_hurr if hurr_used=0.
REQ-018 The block SHALL, on entry to HURR, set hurr_used=1 and load the countdown with CD_SEC (cd_min:cd_sec = 01:00 at default).
REQ-019 The block SHALL, in HURR or COOL, decrement the countdown by one second per edge, borrowing mm:00 -> (mm-1):59.
REQ-020 The block SHALL, in HURR, transition to L2 at the edge where the countdown would go 00:01 -> 00:00, giving exactly CD_SEC edges in HURR.
REQ-021 The block SHALL, in HURR, go to COOL on req_standby and reload the countdown to CD_SEC; req_l1, req_l2 and req_hurr SHALL be ignored in HURR.
REQ-022 The block SHALL, in COOL, ignore all requests and go to STANDBY at the edge where the countdown reaches 00:00.
REQ-023 The block SHALL hold cd_min:cd_sec = 00:00 in STANDBY, L1 and L2.
REQ-024 The block SHALL increment cum_min:cum_sec by one second on every edge at which mode_state (pre-edge) is not 000, wrapping 59:59 -> 00:00.
REQ-025 The block SHALL, when clr_cum=1 at an edge, set cum to 00:00 with priority over increment; mode and countdown SHALL be unaffected.
REQ-026 The block SHALL keep hurr_used=1 until reset; it SHALL never be cleared by mode changes.

Reset
REQ-027 The block SHALL, while rst=0, force mode_state=000, cd=00:00, cum=00:00, hurr_used=0, and all edge-detect registers=0, regardless of clk_1hz.
REQ-028 The block SHALL, on reset asserted mid-HURR or mid-COOL, abort the countdown with no further transitions, and SHALL have hurricane available again after release.

Verification
REQ-029 The bench SHALL check: reset release, pulse req_l1, run 65 edges -> mode_state=001 and cum=01:05.
REQ-030 The bench SHALL check: from STANDBY pulse req_hurr -> mode 011 with cd 01:00, then 00:59 after 1 edge, and mode 010 with cd 00:00 after 60 edges; a second req_hurr is then ignored.
REQ-031 The bench SHALL check: in HURR at cd 00:30 pulse req_standby -> mode 100 with cd 01:00; requests ignored; mode 000 after 60 edges.
REQ-032 The bench SHALL check: simultaneous rising req_standby and req_l2 in L1 -> mode 000 at that edge.
REQ-033 The bench SHALL check: preload cum 59:58 in L2, 2 edges -> 00:00; clr_cum with an edge -> 00:00 while mode holds.
REQ-034 The bench SHALL check: rst low between clocks mid-HURR -> outputs zeroed immediately, and hurr_used=0.
